// File: rtl/ram_view_ctrl.sv
// Lab5 RAM-viewer sequencer: debounced step/select buttons, auto-scan timer,
// and a read FSM that latches one RAM word per advance for the byte mux.

module ram_view_db #(
    parameter int DB_COUNT = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;

    logic [CW-1:0] cnt;

    // A level change is accepted only after DB_COUNT consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (raw == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_COUNT - 1)) begin
            level <= ~level;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

module ram_view_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DB_COUNT = 20,
    parameter int SCAN_DIV = 50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_step,
    input  logic              btn_sel,
    input  logic              auto_en,
    input  logic [15:0]       ram_dout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic [7:0]        addr_byte,
    output logic [7:0]        data_byte,
    output logic [15:0]       data_q,
    output logic              mux_sel,
    output logic              done,
    output logic              busy,
    output logic [1:0]        fsm_state
);
    localparam int SW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        IDLE    = 2'd1,
        READ    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t        state;
    logic          step_lvl;
    logic          step_lvl_q;
    logic          step_pulse;
    logic [SW-1:0] scan_cnt;
    logic          scan_tick;
    logic          trigger;

    ram_view_db #(.DB_COUNT(DB_COUNT)) u_db_step (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_step),
        .level (step_lvl)
    );

    ram_view_db #(.DB_COUNT(DB_COUNT)) u_db_sel (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_sel),
        .level (mux_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            step_lvl_q <= 1'b0;
        end else begin
            step_lvl_q <= step_lvl;
        end
    end

    assign step_pulse = step_lvl & ~step_lvl_q;

    always_ff @(posedge clk) begin
        if (reset || !auto_en || scan_tick) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    assign scan_tick = auto_en && (scan_cnt == SW'(SCAN_DIV - 1));
    assign trigger   = step_pulse | scan_tick;

    // RAM protocol: ram_rd is a one-cycle strobe with ram_addr stable; ram_dout
    // is valid in the following cycle (CAPTURE) and is sampled exactly once.
    // Triggers outside IDLE are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            ram_addr <= '0;
            ram_rd   <= 1'b0;
            data_q   <= '0;
            done     <= 1'b0;
        end else begin
            ram_rd <= 1'b0;
            done   <= 1'b0;
            case (state)
                INIT: begin
                    ram_rd <= 1'b1;
                    state  <= READ;
                end
                IDLE: begin
                    if (trigger) begin
                        ram_addr <= ram_addr + ADDR_W'(1);
                        ram_rd   <= 1'b1;
                        state    <= READ;
                    end
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    data_q <= ram_dout;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

    generate
        if (ADDR_W >= 8) begin : g_addr_trunc
            assign addr_byte = ram_addr[7:0];
        end else begin : g_addr_ext
            assign addr_byte = {{(8 - ADDR_W){1'b0}}, ram_addr};
        end
    endgenerate

    assign data_byte = data_q[15:8];
    // INIT reports busy as soon as reset is released, but never while reset is held.
    assign busy      = (state != IDLE) && !reset;
    assign fsm_state = state;
endmodule

// File: tb/tb_ram_view_ctrl.sv
// Bench for ram_view_ctrl: directed steps plus random button/scan activity,
// checked every cycle against a history-based reference model and a done scoreboard.

module tb_ram_view_ctrl;
    localparam int AW = 4;
    localparam int DB = 20;
    localparam int SD = 50;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          btn_step = 1'b0;
    logic          btn_sel = 1'b0;
    logic          auto_en = 1'b0;
    logic [15:0]   ram_dout = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [7:0]    addr_byte;
    logic [7:0]    data_byte;
    logic [15:0]   data_q;
    logic          mux_sel;
    logic          done;
    logic          busy;
    logic [1:0]    fsm_state;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [15:0] exp_q[$];

    // Reference model: debounced level flips once the last DB raw samples all differ.
    bit            step_hist[$];
    bit            sel_hist[$];
    logic          m_step_lvl = 1'b0;
    logic          m_sel_lvl = 1'b0;
    logic          m_step_rose = 1'b0;
    int            m_run = 0;
    int            m_cd = 3;
    logic [AW-1:0] m_addr = '0;
    logic [15:0]   m_data = '0;
    logic          m_done = 1'b0;
    logic          m_rd = 1'b0;

    ram_view_ctrl #(.ADDR_W(AW), .DB_COUNT(DB), .SCAN_DIV(SD)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_step  (btn_step),
        .btn_sel   (btn_sel),
        .auto_en   (auto_en),
        .ram_dout  (ram_dout),
        .ram_addr  (ram_addr),
        .ram_rd    (ram_rd),
        .addr_byte (addr_byte),
        .data_byte (data_byte),
        .data_q    (data_q),
        .mux_sel   (mux_sel),
        .done      (done),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [AW-1:0] a);
        logic [7:0] b;
        b = 8'(a);
        return {b, ~b};
    endfunction

    // Synchronous-read RAM holding mem[a] = {a, ~a}.
    always @(posedge clk) begin
        if (ram_rd === 1'b1) ram_dout <= word(ram_addr);
    end

    function automatic bit all_differ(input bit h[$], input logic lvl);
        if (h.size() < DB) return 1'b0;
        foreach (h[i]) if (h[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic s_rst, input logic s_step, input logic s_sel,
                              input logic s_auto);
        logic trig;
        if (s_rst) begin
            step_hist.delete();
            sel_hist.delete();
            m_step_lvl  = 1'b0;
            m_sel_lvl   = 1'b0;
            m_step_rose = 1'b0;
            m_run  = 0;
            m_cd   = 3;
            m_addr = '0;
            m_data = '0;
            m_done = 1'b0;
            m_rd   = 1'b0;
            exp_q.delete();
        end else begin
            trig = m_step_rose || (s_auto && (m_run % SD == SD - 1));
            m_step_rose = 1'b0;
            step_hist.push_back(s_step);
            if (step_hist.size() > DB) void'(step_hist.pop_front());
            if (all_differ(step_hist, m_step_lvl)) begin
                m_step_lvl  = ~m_step_lvl;
                m_step_rose = m_step_lvl;
                step_hist.delete();
            end
            sel_hist.push_back(s_sel);
            if (sel_hist.size() > DB) void'(sel_hist.pop_front());
            if (all_differ(sel_hist, m_sel_lvl)) begin
                m_sel_lvl = ~m_sel_lvl;
                sel_hist.delete();
            end
            m_run  = s_auto ? m_run + 1 : 0;
            m_done = 1'b0;
            m_rd   = 1'b0;
            if (m_cd == 0) begin
                if (trig) begin
                    m_addr = m_addr + 1'b1;
                    m_cd   = 2;
                    m_rd   = 1'b1;
                    exp_q.push_back(word(m_addr));
                end
            end else begin
                m_cd--;
                if (m_cd == 2) begin
                    m_rd = 1'b1;
                    exp_q.push_back(word(m_addr));
                end
                if (m_cd == 0) begin
                    m_done = 1'b1;
                    m_data = word(m_addr);
                end
            end
        end
    endtask

    task automatic cyc();
        logic s_rst, s_step, s_sel, s_auto;
        s_rst  = reset;
        s_step = btn_step;
        s_sel  = btn_sel;
        s_auto = auto_en;
        @(posedge clk);
        model_edge(s_rst, s_step, s_sel, s_auto);
        #1;
        chk("ram_addr", 16'(ram_addr), 16'(m_addr));
        chk("ram_rd", 16'(ram_rd), 16'(m_rd));
        chk("done", 16'(done), 16'(m_done));
        chk("data_q", data_q, m_data);
        chk("busy", 16'(busy), 16'((m_cd != 0) && !reset));
        chk("mux_sel", 16'(mux_sel), 16'(m_sel_lvl));
        chk("addr_byte", 16'(addr_byte), 16'(8'(m_addr)));
        chk("data_byte", 16'(data_byte), 16'(m_data[15:8]));
        if (done === 1'b1) begin
            done_cnt++;
            chk("sb_pending", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) chk("sb_data", data_q, exp_q.pop_front());
        end
    endtask

    initial begin
        // Reset and INIT read of address 0.
        repeat (3) cyc();
        chk("rst_addr", 16'(ram_addr), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        reset = 1'b0;
        #1;
        chk("init_busy", 16'(busy), 16'd1);
        repeat (3) cyc();
        chk("init_data", data_q, 16'h00FF);
        chk("init_done", 16'(done), 16'd1);
        chk("init_abyte", 16'(addr_byte), 16'd0);
        chk("init_dbyte", 16'(data_byte), 16'h00);

        // Clean press, then release.
        btn_step = 1'b1;
        done_cnt = 0;
        repeat (40) cyc();
        chk("press_dones", 16'(done_cnt), 16'd1);
        chk("press_addr", 16'(ram_addr), 16'd1);
        chk("press_data", data_q, 16'h01FE);
        chk("press_dbyte", 16'(data_byte), 16'h01);
        btn_step = 1'b0;
        done_cnt = 0;
        repeat (40) cyc();
        chk("release_dones", 16'(done_cnt), 16'd0);

        // Bouncy press settling high.
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            btn_step = ~btn_step;
            repeat (5) cyc();
        end
        btn_step = 1'b1;
        repeat (40) cyc();
        chk("bounce_dones", 16'(done_cnt), 16'd1);
        chk("bounce_addr", 16'(ram_addr), 16'd2);
        btn_step = 1'b0;
        repeat (40) cyc();

        // Auto-scan: ten ticks, then wrap 15 -> 0.
        auto_en = 1'b1;
        done_cnt = 0;
        repeat (503) cyc();
        chk("scan_dones", 16'(done_cnt), 16'd10);
        chk("scan_addr", 16'(ram_addr), 16'd12);
        repeat (150) cyc();
        chk("scan_addr15", 16'(ram_addr), 16'd15);
        repeat (50) cyc();
        chk("scan_wrap", 16'(ram_addr), 16'd0);
        chk("scan_wrap_data", data_q, 16'h00FF);
        auto_en = 1'b0;
        repeat (10) cyc();

        // Step pulse coincident with scan tick: one advance.
        auto_en = 1'b1;
        done_cnt = 0;
        repeat (29) cyc();
        btn_step = 1'b1;
        repeat (31) cyc();
        auto_en = 1'b0;
        chk("coinc_dones", 16'(done_cnt), 16'd1);
        chk("coinc_addr", 16'(ram_addr), 16'd1);
        btn_step = 1'b0;
        repeat (40) cyc();

        // Step pulse one cycle after a tick: second trigger dropped.
        auto_en = 1'b1;
        done_cnt = 0;
        repeat (30) cyc();
        btn_step = 1'b1;
        repeat (30) cyc();
        auto_en = 1'b0;
        chk("drop_dones", 16'(done_cnt), 16'd1);
        chk("drop_addr", 16'(ram_addr), 16'd2);
        btn_step = 1'b0;
        repeat (40) cyc();

        // Random button and scan activity.
        for (int k = 0; k < 25; k++) begin
            btn_step = 1'($urandom_range(0, 1));
            btn_sel  = 1'($urandom_range(0, 1));
            auto_en  = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 40)) cyc();
        end
        btn_step = 1'b0;
        btn_sel  = 1'b0;
        auto_en  = 1'b0;
        repeat (50) cyc();

        // btn_sel held, then reset during READ.
        btn_sel = 1'b1;
        repeat (25) cyc();
        chk("sel_level", 16'(mux_sel), 16'd1);
        btn_step = 1'b1;
        for (int i = 0; i < 60 && m_cd != 2; i++) cyc();
        chk("mid_read_rd", 16'(ram_rd), 16'd1);
        chk("mid_read_sel", 16'(mux_sel), 16'd1);
        reset    = 1'b1;
        btn_step = 1'b0;
        btn_sel  = 1'b0;
        cyc();
        chk("abort_addr", 16'(ram_addr), 16'd0);
        chk("abort_rd", 16'(ram_rd), 16'd0);
        chk("abort_data", data_q, 16'h0000);
        chk("abort_sel", 16'(mux_sel), 16'd0);
        chk("abort_done", 16'(done), 16'd0);
        reset = 1'b0;
        #1;
        chk("reinit_busy", 16'(busy), 16'd1);
        repeat (3) cyc();
        chk("reinit_data", data_q, 16'h00FF);
        chk("reinit_done", 16'(done), 16'd1);
        repeat (5) cyc();

        chk("sb_drain", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
